// File: rtl/router_pkt_tx_pkg.sv
// +----------------------------------------------------------------------------+
// | router_pkt_tx_pkg : shared types and header packing for the packet source  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package router_pkt_tx_pkg;

  localparam int                    HDR_LEN_W    = 6;
  localparam int                    HDR_ADDR_W   = 2;
  localparam logic [HDR_ADDR_W-1:0] MAX_PORT     = 2'd2;
  localparam logic [7:0]            CORRUPT_MASK = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_t;

  function automatic logic [7:0] pack_header(input logic [HDR_LEN_W-1:0]  len,
                                             input logic [HDR_ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_pkt_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | router_pkt_tx_fifo : DEPTH x 8 first-word-fall-through payload buffer      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module router_pkt_tx_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full buffer still takes the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/router_pkt_tx.sv
// +----------------------------------------------------------------------------+
// | router_pkt_tx : buffered header/payload/parity packet source for router    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int BUF_DEPTH = 64,
  parameter int CNT_W     = 7,
  parameter int GAP_CYC   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  output logic                 buf_full,
  output logic [CNT_W-1:0]     buf_count,
  input  logic                 start,
  input  logic [HDR_ADDR_W-1:0] dest_addr,
  input  logic [HDR_LEN_W-1:0] payload_len,
  input  logic                 corrupt_parity,
  input  logic                 busy,
  output logic                 pkt_valid,
  output logic [7:0]           data_out,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 req_rej
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  tx_state_t            state, state_nx;
  logic [7:0]           data_nx;
  logic                 valid_nx, done_nx, rej_nx;
  logic [HDR_LEN_W-1:0] len_q, len_nx;
  logic [HDR_LEN_W-1:0] remaining, rem_nx;
  logic [7:0]           parity, par_nx;
  logic                 corrupt_q, corrupt_nx;
  logic [GAP_W-1:0]     gap_cnt, gap_nx;
  logic                 pop_req;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;
  logic                 start_legal;

  router_pkt_tx_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (buf_full),
    .empty     (fifo_empty),
    .count     (buf_count)
  );

  assign tx_ready    = (state == ST_IDLE);
  assign fifo_pop    = pop_req & ~fifo_empty;
  // Length is checked against the buffer up front, so the payload can never underrun.
  assign start_legal = (dest_addr <= MAX_PORT) && (payload_len != '0) &&
                       (buf_count >= CNT_W'(payload_len));

  always_comb begin
    state_nx   = state;
    data_nx    = data_out;
    valid_nx   = pkt_valid;
    done_nx    = 1'b0;
    rej_nx     = 1'b0;
    len_nx     = len_q;
    rem_nx     = remaining;
    par_nx     = parity;
    corrupt_nx = corrupt_q;
    gap_nx     = gap_cnt;
    pop_req    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (start_legal) begin
            data_nx    = pack_header(payload_len, dest_addr);
            par_nx     = pack_header(payload_len, dest_addr);
            valid_nx   = 1'b1;
            len_nx     = payload_len;
            corrupt_nx = corrupt_parity;
            state_nx   = ST_HEADER;
          end else begin
            rej_nx = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          data_nx  = fifo_head;
          par_nx   = parity ^ fifo_head;
          pop_req  = 1'b1;
          rem_nx   = len_q;
          state_nx = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          rem_nx = remaining - HDR_LEN_W'(1);
          if (remaining > HDR_LEN_W'(1)) begin
            data_nx = fifo_head;
            par_nx  = parity ^ fifo_head;
            pop_req = 1'b1;
          end else begin
            valid_nx = 1'b0;
            data_nx  = parity ^ (corrupt_q ? CORRUPT_MASK : 8'h00);
            state_nx = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          done_nx  = 1'b1;
          data_nx  = 8'h00;
          gap_nx   = GAP_W'(GAP_CYC - 1);
          state_nx = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nx = ST_IDLE;
        else               gap_nx   = gap_cnt - GAP_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      req_rej   <= 1'b0;
      len_q     <= '0;
      remaining <= '0;
      parity    <= 8'h00;
      corrupt_q <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      data_out  <= data_nx;
      pkt_valid <= valid_nx;
      tx_done   <= done_nx;
      req_rej   <= rej_nx;
      len_q     <= len_nx;
      remaining <= rem_nx;
      parity    <= par_nx;
      corrupt_q <= corrupt_nx;
      gap_cnt   <= gap_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
// +----------------------------------------------------------------------------+
// | tb_router_pkt_tx : directed and random checks of the router packet source  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_router_pkt_tx;

  localparam int DEPTH   = 64;
  localparam int GAP_CYC = 1;
  localparam int M_IDLE  = 0;
  localparam int M_SEND  = 1;
  localparam int M_GAP   = 2;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       corrupt_parity;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_ready;
  logic       tx_done;
  logic       req_rej;

  int checks = 0;
  int errors = 0;

  router_pkt_tx #(
    .BUF_DEPTH (DEPTH),
    .CNT_W     (7),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .buf_full       (buf_full),
    .buf_count      (buf_count),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .corrupt_parity (corrupt_parity),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_out       (data_out),
    .tx_ready       (tx_ready),
    .tx_done        (tx_done),
    .req_rej        (req_rej)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Reference model: buffer as a queue, an accepted packet as the list of bytes it must emit.
  logic [7:0] q[$];
  logic [7:0] stream[$];
  int         idx;
  int         s_len;
  int         mode;
  int         gap_left;
  logic       e_valid;
  logic [7:0] e_data;
  logic       e_done;
  logic       e_rej;
  bit         model_on = 0;

  task automatic model_step();
    bit         do_pop;
    bit         was_full;
    bit         legal;
    logic [7:0] par;
    logic [7:0] dummy;
    do_pop = 0;
    if (reset) begin
      q.delete();
      stream.delete();
      mode     = M_IDLE;
      e_valid  = 1'b0;
      e_data   = 8'h00;
      e_done   = 1'b0;
      e_rej    = 1'b0;
      model_on = 1;
      return;
    end
    if (!model_on) return;
    e_done   = 1'b0;
    e_rej    = 1'b0;
    was_full = (q.size() == DEPTH);
    case (mode)
      M_IDLE: if (start) begin
        legal = (dest_addr != 2'd3) && (payload_len != 6'd0) && (q.size() >= int'(payload_len));
        if (legal) begin
          stream.delete();
          par = {payload_len, dest_addr};
          stream.push_back(par);
          for (int i = 0; i < int'(payload_len); i++) begin
            stream.push_back(q[i]);
            par = par ^ q[i];
          end
          stream.push_back(corrupt_parity ? (par ^ 8'h01) : par);
          s_len   = int'(payload_len);
          idx     = 0;
          e_data  = stream[0];
          e_valid = 1'b1;
          mode    = M_SEND;
        end else begin
          e_rej = 1'b1;
        end
      end
      M_SEND: if (!busy) begin
        idx++;
        if (idx < stream.size()) begin
          e_data  = stream[idx];
          e_valid = (idx <= s_len);
          do_pop  = (idx <= s_len);
        end else begin
          e_done   = 1'b1;
          e_data   = 8'h00;
          e_valid  = 1'b0;
          gap_left = GAP_CYC;
          mode     = M_GAP;
        end
      end
      default: begin
        gap_left--;
        if (gap_left <= 0) mode = M_IDLE;
      end
    endcase
    if (do_pop) dummy = q.pop_front();
    if (wr_en && (!was_full || do_pop)) q.push_back(wr_data);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (model_on) begin
      chk("pkt_valid", 32'(pkt_valid), 32'(e_valid));
      chk("data_out",  32'(data_out),  32'(e_data));
      chk("tx_ready",  32'(tx_ready),  32'(mode == M_IDLE));
      chk("tx_done",   32'(tx_done),   32'(e_done));
      chk("req_rej",   32'(req_rej),   32'(e_rej));
      chk("buf_count", 32'(buf_count), 32'(q.size()));
      chk("buf_full",  32'(buf_full),  32'(q.size() == DEPTH));
    end
  end

  task automatic load3();
    logic [7:0] b [3];
    b[0] = 8'hA5; b[1] = 8'h3C; b[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = b[i]; tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] a, input logic [5:0] l, input logic c);
    start = 1'b1; dest_addr = a; payload_len = l; corrupt_parity = c;
    tick();
    start = 1'b0; corrupt_parity = 1'b0;
  endtask

  function automatic logic [31:0] vd();
    return 32'({pkt_valid, data_out});
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; dest_addr = 2'd0;
    payload_len = 6'd0; corrupt_parity = 1'b0; busy = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_vd", vd(), 32'h000);
    reset = 1'b0;

    // Basic packet: header 0E, payload A5 3C FF, parity 68
    load3();
    go(2'd2, 6'd3, 1'b0);
    chk("t1_hdr", vd(), 32'h10E); tick();
    chk("t1_p0", vd(), 32'h1A5);  tick();
    chk("t1_p1", vd(), 32'h13C);  tick();
    chk("t1_p2", vd(), 32'h1FF);  tick();
    chk("t1_par", vd(), 32'h068); tick();
    chk("t1_done", 32'({tx_done, tx_ready}), 32'h2); tick();
    chk("t1_ready", 32'({tx_done, tx_ready}), 32'h1);

    // Busy stall while 3C is presented
    load3();
    go(2'd2, 6'd3, 1'b0);
    chk("t2_hdr", vd(), 32'h10E); tick();
    chk("t2_p0", vd(), 32'h1A5);  tick();
    chk("t2_p1a", vd(), 32'h13C); busy = 1'b1; tick();
    chk("t2_p1b", vd(), 32'h13C); tick();
    chk("t2_p1c", vd(), 32'h13C); busy = 1'b0; tick();
    chk("t2_p2", vd(), 32'h1FF);  tick();
    chk("t2_par", vd(), 32'h068); tick();
    chk("t2_done", 32'(tx_done), 32'd1); tick();

    // Corrupted parity
    load3();
    go(2'd2, 6'd3, 1'b1);
    repeat (4) tick();
    chk("t3_par", vd(), 32'h069); tick();
    chk("t3_done", 32'(tx_done), 32'd1);
    chk("t3_empty", 32'(buf_count), 32'd0); tick();

    // Illegal requests
    load3();
    go(2'd3, 6'd3, 1'b0);
    chk("t4_addr_rej", 32'({req_rej, pkt_valid}), 32'h2);
    chk("t4_addr_cnt", 32'(buf_count), 32'd3); tick();
    chk("t4_pulse", 32'(req_rej), 32'd0);
    go(2'd0, 6'd0, 1'b0);
    chk("t4_len0_rej", 32'({req_rej, pkt_valid}), 32'h2);
    go(2'd0, 6'd5, 1'b0);
    chk("t4_short_rej", 32'({req_rej, pkt_valid}), 32'h2);
    chk("t4_short_cnt", 32'(buf_count), 32'd3);
    reset = 1'b1; tick(); reset = 1'b0;

    // Fill, overflow, then a 63-byte packet with concurrent writes
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); tick();
    end
    chk("t5_full", 32'({buf_full, buf_count}), 32'({1'b1, 7'd64}));
    wr_data = 8'hEE; tick();
    chk("t5_drop", 32'(buf_count), 32'd64);
    wr_en = 1'b1; wr_data = 8'h5A;
    go(2'd1, 6'd63, 1'b0);
    for (int n = 0; n < 300 && !tx_ready; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_data = 8'($urandom); tick();
    end
    wr_en = 1'b0;
    chk("t5_finish", 32'(tx_ready), 32'd1);

    // Reset during payload
    reset = 1'b1; tick(); reset = 1'b0;
    load3();
    go(2'd0, 6'd3, 1'b0); tick();
    chk("t6_in_payload", vd(), 32'h1A5);
    reset = 1'b1; tick();
    chk("t6_vd", vd(), 32'h000);
    chk("t6_cnt_ready", 32'({buf_count, tx_ready}), 32'h01);
    reset = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      wr_en          = ($urandom_range(0, 2) != 0);
      wr_data        = 8'($urandom);
      busy           = ($urandom_range(0, 3) == 0);
      start          = ($urandom_range(0, 5) == 0);
      dest_addr      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      payload_len    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(1, 8));
      corrupt_parity = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; wr_en = 1'b0; busy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
